// File: rtl/cas3_window.sv
// cas3_window: streaming 3-sample sliding window in front of a cas3
// compare-and-swap sorter, with a registered max/mid/min output stage.
// Optional build macro: CAS3_ORDER_CHECK_EN adds the sticky order_err port.

// cas3: purely combinational 3-input sorter (a_new >= b_new >= c_new, unsigned)
module cas3 #(
   parameter int BITS = 6
) (
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic [BITS-1:0] c,
   output logic [BITS-1:0] a_new,
   output logic [BITS-1:0] b_new,
   output logic [BITS-1:0] c_new
);

   logic [BITS-1:0] hi1;
   logic [BITS-1:0] lo1;
   logic [BITS-1:0] hi2;

   // Three compare-and-swap stages; ties keep the earlier operand on top so
   // duplicates pass through unchanged.
   always_comb begin
      hi1   = (a >= b) ? a : b;
      lo1   = (a >= b) ? b : a;
      hi2   = (lo1 >= c) ? lo1 : c;
      c_new = (lo1 >= c) ? c : lo1;
      a_new = (hi1 >= hi2) ? hi1 : hi2;
      b_new = (hi1 >= hi2) ? hi2 : hi1;
   end

endmodule

module cas3_window #(
   parameter int BITS = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [BITS-1:0] in_data,
   input  logic            flush,
   output logic [1:0]      fill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BITS-1:0] out_max,
   output logic [BITS-1:0] out_mid,
   output logic [BITS-1:0] out_min
`ifdef CAS3_ORDER_CHECK_EN
   ,
   output logic            order_err
`endif
);

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      fill_q, fill_d;
   logic            win_vld_q, win_vld_d;
   logic [BITS-1:0] w0_q, w1_q, w2_q;
   logic            out_valid_q, out_valid_d;
   logic [BITS-1:0] max_q, mid_q, min_q;

   logic            accept;
   logic            load;
   logic [BITS-1:0] s_max, s_mid, s_min;

   // Sorter sees the oldest sample on a and the newest on c
   cas3 #(.BITS(BITS)) u_cas3 (
      .a     (w2_q),
      .b     (w1_q),
      .c     (w0_q),
      .a_new (s_max),
      .b_new (s_mid),
      .c_new (s_min)
   );

   // Handshakes, fill counting and FILL/RUN sequencing; flush overrides everything
   // except the output stage, which keeps delivering what it already holds.
   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      win_vld_d   = win_vld_q;
      out_valid_d = out_valid_q;

      load     = win_vld_q && (!out_valid_q || out_ready);
      in_ready = !flush && (!win_vld_q || load);
      accept   = in_valid && in_ready;

      if (load) begin
         out_valid_d = 1'b1;
         win_vld_d   = 1'b0;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (flush) begin
         state_d   = ST_FILL;
         fill_d    = 2'd0;
         win_vld_d = 1'b0;
      end else if (accept) begin
         unique case (state_q)
            ST_FILL: begin
               fill_d = fill_q + 2'd1;
               if (fill_q == 2'd2) begin
                  state_d   = ST_RUN;
                  win_vld_d = 1'b1;
               end
            end
            ST_RUN: begin
               fill_d    = 2'd3;
               win_vld_d = 1'b1;
            end
            default: state_d = ST_FILL;
         endcase
      end
   end

   // Control state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_FILL;
         fill_q      <= 2'd0;
         win_vld_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         win_vld_q   <= win_vld_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Window shift register: newest sample enters at w0 on every accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w0_q <= '0;
         w1_q <= '0;
         w2_q <= '0;
      end else if (accept) begin
         w2_q <= w1_q;
         w1_q <= w0_q;
         w0_q <= in_data;
      end
   end

   // Output triple captures the pre-shift window whenever the output stage takes it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_q <= '0;
         mid_q <= '0;
         min_q <= '0;
      end else if (load) begin
         max_q <= s_max;
         mid_q <= s_mid;
         min_q <= s_min;
      end
   end

`ifdef CAS3_ORDER_CHECK_EN
   // Sticky flag if the sorter ever hands over a triple that is not ordered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         order_err <= 1'b0;
      end else if (load && !((s_max >= s_mid) && (s_mid >= s_min))) begin
         order_err <= 1'b1;
      end
   end
`else
   // Without the checker the datapath is identical and no fault flag exists.
`endif

   assign fill      = fill_q;
   assign out_valid = out_valid_q;
   assign out_max   = max_q;
   assign out_mid   = mid_q;
   assign out_min   = min_q;

endmodule

// File: tb/tb_cas3_window.sv
// tb_cas3_window: directed test-plan sequences plus randomized traffic, all
// checked against a transaction-level model of the sliding-window sorter.

module tb_cas3_window;

   localparam int BITS = 6;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [BITS-1:0] in_data;
   logic            flush;
   logic [1:0]      fill;
   logic            out_valid;
   logic            out_ready;
   logic [BITS-1:0] out_max;
   logic [BITS-1:0] out_mid;
   logic [BITS-1:0] out_min;
`ifdef CAS3_ORDER_CHECK_EN
   logic            order_err;
`endif

   int total = 0;
   int bad   = 0;

   // Model: accepted samples since the last flush/reset (last 3 kept), one
   // triple waiting behind the output, and the triple currently presented.
   int hist[$];
   bit mWin;
   int mWinMax, mWinMid, mWinMin;
   bit mOutV;
   int mOutMax, mOutMid, mOutMin;

   cas3_window #(.BITS(BITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush     (flush),
      .fill      (fill),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_max   (out_max),
      .out_mid   (out_mid),
      .out_min   (out_min)
`ifdef CAS3_ORDER_CHECK_EN
      ,
      .order_err (order_err)
`endif
   );

   // 10-unit clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void sortThree(input int a, input int b, input int c,
                                     output int mx, output int md, output int mn);
      mx = a;
      if (b > mx) mx = b;
      if (c > mx) mx = c;
      mn = a;
      if (b < mn) mn = b;
      if (c < mn) mn = c;
      md = a + b + c - mx - mn;
   endfunction

   task automatic modelReset();
      hist.delete();
      mWin    = 1'b0;
      mOutV   = 1'b0;
      mOutMax = 0;
      mOutMid = 0;
      mOutMin = 0;
   endtask

   // Drive one cycle, check every observable against the model before the
   // edge, then advance the model through that edge.
   task automatic applyStimulus(input bit v, input int d, input bit ordy, input bit fl);
      bit mLoad, mRdy, acc;
      in_valid  = v;
      in_data   = d[BITS-1:0];
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      mLoad = mWin && (!mOutV || ordy);
      mRdy  = !fl && (!mWin || mLoad);
      acc   = v && mRdy;
      checkOutput("in_ready", in_ready, mRdy);
      checkOutput("fill", fill, hist.size());
      checkOutput("out_valid", out_valid, mOutV);
      if (mOutV) begin
         checkOutput("out_max", out_max, mOutMax);
         checkOutput("out_mid", out_mid, mOutMid);
         checkOutput("out_min", out_min, mOutMin);
      end
      if (mLoad) begin
         mOutV   = 1'b1;
         mOutMax = mWinMax;
         mOutMid = mWinMid;
         mOutMin = mWinMin;
      end else if (mOutV && ordy) begin
         mOutV = 1'b0;
      end
      if (fl) begin
         hist.delete();
         mWin = 1'b0;
      end else begin
         if (mLoad) mWin = 1'b0;
         if (acc) begin
            hist.push_back(d);
            if (hist.size() > 3) void'(hist.pop_front());
            if (hist.size() == 3) begin
               mWin = 1'b1;
               sortThree(hist[0], hist[1], hist[2], mWinMax, mWinMid, mWinMin);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkTriple(input string tag, input int mx, input int md, input int mn);
      checkOutput({tag, "_valid"}, out_valid, 1);
      checkOutput({tag, "_max"}, out_max, mx);
      checkOutput({tag, "_mid"}, out_mid, md);
      checkOutput({tag, "_min"}, out_min, mn);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_in_ready"}, in_ready, 1);
      checkOutput({tag, "_fill"}, fill, 0);
      checkOutput({tag, "_out_valid"}, out_valid, 0);
      checkOutput({tag, "_out_max"}, out_max, 0);
      checkOutput({tag, "_out_mid"}, out_mid, 0);
      checkOutput({tag, "_out_min"}, out_min, 0);
`ifdef CAS3_ORDER_CHECK_EN
      checkOutput({tag, "_order_err"}, order_err, 0);
`endif
   endtask

   // Reset asserted between edges must clear the block without a clock edge
   task automatic midReset();
      #2;
      in_valid = 1'b0;
      flush    = 1'b0;
      rst      = 1'b1;
      #1;
      checkResetValues("async_rst");
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkResetValues("reset");
      rst = 1'b0;

      // Fill and sliding
      applyStimulus(1, 10, 1, 0);
      checkOutput("fill_1", fill, 1);
      applyStimulus(1, 40, 1, 0);
      checkOutput("fill_2", fill, 2);
      applyStimulus(1, 25, 1, 0);
      checkOutput("fill_3", fill, 3);
      checkOutput("fill_noout", out_valid, 0);
      applyStimulus(1, 63, 1, 0);
      checkTriple("first", 40, 25, 10);
      applyStimulus(1, 0, 1, 0);
      checkTriple("slide1", 63, 40, 25);
      applyStimulus(0, 0, 1, 0);
      checkTriple("slide2", 63, 25, 0);
      applyStimulus(0, 0, 1, 0);
      checkOutput("slide_drain", out_valid, 0);

      // Backpressure: one more sample is taken, then in_ready drops
      for (int i = 0; i < 5; i++) applyStimulus(1, 11 + i, 0, 0);
      checkOutput("bp_stall", in_ready, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0);

      // Duplicates and bounds
      applyStimulus(0, 0, 1, 1);
      applyStimulus(1, 63, 1, 0);
      applyStimulus(1, 63, 1, 0);
      applyStimulus(1, 0, 1, 0);
      applyStimulus(0, 0, 1, 0);
      checkTriple("dup_63", 63, 63, 0);
      applyStimulus(0, 0, 1, 1);
      applyStimulus(1, 7, 1, 0);
      applyStimulus(1, 7, 1, 0);
      applyStimulus(1, 7, 1, 0);
      applyStimulus(0, 0, 1, 0);
      checkTriple("dup_7", 7, 7, 7);

      // Flush with a triple pending at the output
      applyStimulus(0, 0, 1, 1);
      applyStimulus(1, 5, 0, 0);
      applyStimulus(1, 9, 0, 0);
      applyStimulus(1, 2, 0, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 33, 0, 1);
      checkOutput("flush_fill", fill, 0);
      checkTriple("flush_pend", 9, 5, 2);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(1, 1, 1, 0);
      applyStimulus(1, 2, 1, 0);
      checkOutput("flush_refill", out_valid, 0);
      applyStimulus(1, 3, 1, 0);
      applyStimulus(0, 0, 1, 0);
      checkTriple("flush_next", 3, 2, 1);

      // Randomized traffic with an asynchronous reset in the middle
      for (int i = 0; i < 1200; i++) begin
         int d;
         case ($urandom_range(0, 7))
            0:       d = 0;
            1:       d = 63;
            default: d = $urandom_range(0, 63);
         endcase
         if (i == 600) midReset();
         applyStimulus($urandom_range(0, 3) != 0, d, $urandom_range(0, 4) > 1,
                       $urandom_range(0, 40) == 0);
      end
`ifdef CAS3_ORDER_CHECK_EN
      checkOutput("order_err_end", order_err, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
